// File: rtl/display_scan_controller.sv
// display_scan_controller: sequences the 4:1 digit mux of a seven-segment display.
// Each enabled digit is shown for PRESCALE cycles. An optional BLANK_CYCLES dead-time
// precedes every slot. Digits with a clear mask bit are skipped. frame_done pulses on
// the first cycle of the slot that begins a new pass through the enabled digits.
module display_scan_controller #(
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit_mask,
   output logic [1:0] scan,
   output logic [3:0] digit_en,
   output logic       blank,
   output logic       frame_done
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StBlank = 2'd1;
   localparam logic [1:0] StShow  = 2'd2;

   // Terminal counts. BlankLast is never reached when BLANK_CYCLES is 0, because the
   // BLANK state is then never entered.
   localparam logic [CNT_W-1:0] ShowLast  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BlankLast = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1)
                                                               : '0;
   localparam logic             HasBlank  = (BLANK_CYCLES > 0);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       scan_q, scan_d;
   logic [3:0]       digit_en_q, digit_en_d;
   logic             blank_q, blank_d;
   logic             frame_done_q, frame_done_d;
   logic [1:0]       sel_scan;

   // Index of the lowest set bit of the mask. Returns 0 for an empty mask.
   function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // First set bit strictly after cur, searching cyclically. The last candidate is cur
   // itself, so a lone enabled digit selects itself again.
   function automatic logic [1:0] next_bit(input logic [1:0] cur, input logic [3:0] mask);
      logic [1:0] idx;
      logic [1:0] cand;
      logic       found;
      idx   = cur;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = cur + 2'(k);
         if (!found && mask[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   // Next-state logic. The outputs are derived from the next state, so they are
   // registered and change in the same cycle as the state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      scan_d       = scan_q;
      frame_done_d = 1'b0;
      sel_scan     = next_bit(scan_q, digit_mask);

      if (!enable) begin
         // Abort any slot in progress. scan keeps its last value.
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (digit_mask != 4'b0000) begin
                  scan_d  = lowest_bit(digit_mask);
                  cnt_d   = '0;
                  state_d = HasBlank ? StBlank : StShow;
               end
            end
            StBlank: begin
               if (cnt_q == BlankLast) begin
                  state_d = StShow;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StShow: begin
               if (cnt_q == ShowLast) begin
                  // The mask is sampled only here, so a mid-slot edit never cuts a slot short.
                  cnt_d = '0;
                  if (digit_mask == 4'b0000) begin
                     state_d = StIdle;
                  end else begin
                     scan_d       = sel_scan;
                     state_d      = HasBlank ? StBlank : StShow;
                     frame_done_d = (sel_scan <= scan_q);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      digit_en_d = (state_d == StShow) ? (4'b0001 << scan_d) : 4'b0000;
      blank_d    = (state_d != StShow);
   end

   // State and output registers. Reset is asynchronous, so outputs blank at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         scan_q       <= 2'd0;
         digit_en_q   <= 4'b0000;
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         scan_q       <= scan_d;
         digit_en_q   <= digit_en_d;
         blank_q      <= blank_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign scan       = scan_q;
   assign digit_en   = digit_en_q;
   assign blank      = blank_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: u0 uses PRESCALE=4, BLANK_CYCLES=1,
// and u1 uses PRESCALE=4, BLANK_CYCLES=0.
module tb_display_scan_controller;

   logic       clock;
   logic       reset;
   logic       enable, enable1;
   logic [3:0] mask, mask1;
   logic [1:0] scan, scan1;
   logic [3:0] den, den1;
   logic       blank, blank1;
   logic       fd, fd1;

   int tests = 0;
   int fails = 0;

   display_scan_controller #(.PRESCALE(4), .BLANK_CYCLES(1), .CNT_W(16)) u0 (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .digit_mask (mask),
      .scan       (scan),
      .digit_en   (den),
      .blank      (blank),
      .frame_done (fd)
   );

   display_scan_controller #(.PRESCALE(4), .BLANK_CYCLES(0), .CNT_W(16)) u1 (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable1),
      .digit_mask (mask1),
      .scan       (scan1),
      .digit_en   (den1),
      .blank      (blank1),
      .frame_done (fd1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_u0(input string tag, input logic [1:0] e_scan, input logic [3:0] e_en,
                         input logic e_blank, input logic e_fd);
      chk({tag, ".scan"},  32'(scan),  32'(e_scan));
      chk({tag, ".en"},    32'(den),   32'(e_en));
      chk({tag, ".blank"}, 32'(blank), 32'(e_blank));
      chk({tag, ".fd"},    32'(fd),    32'(e_fd));
   endtask

   task automatic chk_u1(input string tag, input logic [1:0] e_scan, input logic [3:0] e_en,
                         input logic e_blank, input logic e_fd);
      chk({tag, ".scan"},  32'(scan1),  32'(e_scan));
      chk({tag, ".en"},    32'(den1),   32'(e_en));
      chk({tag, ".blank"}, 32'(blank1), 32'(e_blank));
      chk({tag, ".fd"},    32'(fd1),    32'(e_fd));
   endtask

   // Full-mask pattern, cycle c counted from 1 after enable: 1 blank then 4 show per digit.
   task automatic chk_full(input int c);
      int         ph;
      logic [1:0] d;
      ph = (c - 1) % 5;
      d  = 2'(((c - 1) / 5) % 4);
      if (ph == 0) chk_u0($sformatf("full_c%0d", c), d, 4'b0000, 1'b1, (d == 2'd0) && (c > 1));
      else         chk_u0($sformatf("full_c%0d", c), d, 4'b0001 << d, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int p;
      reset   = 1'b1;
      enable  = 1'b0;
      mask    = 4'h0;
      enable1 = 1'b0;
      mask1   = 4'h0;
      #1;
      chk_u0("rst", 2'd0, 4'b0000, 1'b1, 1'b0);
      chk_u1("rst1", 2'd0, 4'b0000, 1'b1, 1'b0);
      #1 reset = 1'b0;
      step();
      chk_u0("idle", 2'd0, 4'b0000, 1'b1, 1'b0);

      // Start full scan and run into the digit-2 slot.
      enable = 1'b1;
      mask   = 4'hF;
      for (int c = 1; c <= 13; c++) begin
         step();
         chk_full(c);
      end

      // Asynchronous reset mid-SHOW at scan=2.
      #1 reset = 1'b1;
      #1 chk_u0("rst_mid", 2'd0, 4'b0000, 1'b1, 1'b0);
      #1 reset = 1'b0;

      // Restart from digit 0, two full frames plus one digit.
      for (int c = 1; c <= 42; c++) begin
         step();
         chk_full(c);
      end

      // Skipping: new mask takes effect after the current digit-0 slot.
      mask = 4'b1010;
      for (int c = 43; c <= 75; c++) begin
         step();
         if (c <= 45) begin
            chk_u0($sformatf("skip_c%0d", c), 2'd0, 4'b0001, 1'b0, 1'b0);
         end else begin
            p = (c - 46) % 10;
            if (p == 0)      chk_u0($sformatf("skip_c%0d", c), 2'd1, 4'b0000, 1'b1, c >= 56);
            else if (p < 5)  chk_u0($sformatf("skip_c%0d", c), 2'd1, 4'b0010, 1'b0, 1'b0);
            else if (p == 5) chk_u0($sformatf("skip_c%0d", c), 2'd3, 4'b0000, 1'b1, 1'b0);
            else             chk_u0($sformatf("skip_c%0d", c), 2'd3, 4'b1000, 1'b0, 1'b0);
         end
      end
      step();
      chk_u0("skip_wrap", 2'd1, 4'b0000, 1'b1, 1'b1);
      step();
      chk_u0("d1_cyc1", 2'd1, 4'b0010, 1'b0, 1'b0);
      step();
      chk_u0("d1_cyc2", 2'd1, 4'b0010, 1'b0, 1'b0);

      // Enable drop mid-SHOW, then restart.
      enable = 1'b0;
      step();
      chk_u0("drop_idle", 2'd1, 4'b0000, 1'b1, 1'b0);
      step();
      chk_u0("drop_idle2", 2'd1, 4'b0000, 1'b1, 1'b0);
      enable = 1'b1;
      step();
      chk_u0("reen_blank", 2'd1, 4'b0000, 1'b1, 1'b0);
      step();
      chk_u0("reen_show", 2'd1, 4'b0010, 1'b0, 1'b0);

      // Clear bit 1 while digit 1 shows: the slot completes, then digit 3.
      mask = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_u0($sformatf("clr1_show%0d", i), 2'd1, 4'b0010, 1'b0, 1'b0);
      end
      step();
      chk_u0("clr1_blank3", 2'd3, 4'b0000, 1'b1, 1'b0);
      step();
      chk_u0("d3_cyc1", 2'd3, 4'b1000, 1'b0, 1'b0);
      step();
      chk_u0("d3_cyc2", 2'd3, 4'b1000, 1'b0, 1'b0);

      // Clear the whole mask during digit 3: finish the slot, then IDLE.
      mask = 4'b0000;
      step();
      chk_u0("d3_cyc3", 2'd3, 4'b1000, 1'b0, 1'b0);
      step();
      chk_u0("d3_cyc4", 2'd3, 4'b1000, 1'b0, 1'b0);
      step();
      chk_u0("mask0_idle", 2'd3, 4'b0000, 1'b1, 1'b0);
      step();
      chk_u0("mask0_idle2", 2'd3, 4'b0000, 1'b1, 1'b0);

      // Single digit, no blanking: digit 2 stays lit, frame_done every 4 cycles.
      mask1   = 4'b0100;
      enable1 = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         step();
         chk_u1($sformatf("single_c%0d", c), 2'd2, 4'b0100, 1'b0, (c > 1) && ((c - 1) % 4 == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Sequencer for the 4-digit seven-segment display path. It drives the 2-bit `scan` select of the 4:1 digit multiplexer and the matching one-hot digit enables. Each digit is held for a programmable number of cycles, with optional blanking dead-time between digits to suppress ghosting. Digits whose mask bit is clear are skipped. A one-cycle `frame_done` pulse marks each full refresh of the enabled digits.

Parameters:
- PRESCALE, 1000, clock cycles per digit SHOW slot; legal range 1..65535.
- BLANK_CYCLES, 16, clock cycles of blanking before each SHOW slot; legal range 0..65535; 0 removes the BLANK state.
- CNT_W, 16, width of the internal slot counter; must hold max(PRESCALE, BLANK_CYCLES)-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning runs; 0 = display blanked, controller idle.
- digit_mask  input  4  bit i = 1 means digit i is scanned; bit 0 is the rightmost digit.
- scan  output  2  select to the digit mux (0..3); registered.
- digit_en  output  4  one-hot active-high digit enable, equal to 1<<scan during SHOW, 0 otherwise; registered.
- blank  output  1  1 when no digit is enabled (IDLE or BLANK); registered, equals (digit_en==0).
- frame_done  output  1  one-cycle pulse on wrap-around of the scan sequence; registered.

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE, scan=0, digit_en=0, blank=1, frame_done=0, counter=0.
  - Outputs change immediately on reset assertion, without waiting for a clock edge.
- States: IDLE, BLANK, SHOW. `digit_en` is nonzero only in SHOW.
- IDLE:
  - Outputs: digit_en=0, blank=1, scan holds its last value.
  - If enable=1 and digit_mask!=0: next scan = lowest set bit of digit_mask; go to BLANK (counter=0), or to SHOW if BLANK_CYCLES==0. frame_done is not pulsed on this entry.
  - Otherwise remain in IDLE.
- BLANK:
  - Lasts exactly BLANK_CYCLES cycles; digit_en=0, blank=1, scan already shows the upcoming digit.
  - After the last cycle: go to SHOW with counter=0.
- SHOW:
  - Lasts exactly PRESCALE cycles; digit_en=1<<scan, blank=0.
  - On the last cycle, sample digit_mask:
    - If mask==0: go to IDLE.
    - Otherwise: next scan = first set bit strictly after scan, cyclic (3 wraps to 0). The candidate can be scan itself when it is the only set bit.
    - Go to BLANK, or to SHOW if BLANK_CYCLES==0.
- Wrap detection: when the next index is less than or equal to the current index, frame_done=1 for exactly the first cycle of the new slot.
- Latency from enable: enable rising while idle with mask!=0 gives the first digit_en assertion BLANK_CYCLES+1 cycles later.
- enable=0 in any state: next cycle IDLE, digit_en=0, blank=1, frame_done=0; an in-progress slot is aborted.
- digit_mask changes mid-slot: the current slot completes unchanged, even if its own bit was cleared. The new mask takes effect only at the next selection point.
- Single enabled digit: that digit repeats.
  - With BLANK_CYCLES>0 it blinks through a BLANK slot every period.
  - frame_done pulses every period, i.e. every PRESCALE+BLANK_CYCLES cycles.
- Period: PRESCALE+BLANK_CYCLES cycles per enabled digit. Frame period = N_enabled × that.
- Counter arithmetic is unsigned. It compares against PRESCALE-1 and BLANK_CYCLES-1 and never overflows at legal parameter values.
- Out-of-range parameter values are not supported (illegal configuration).

Test Plan:
- Bench parameters: PRESCALE=4, BLANK_CYCLES=1 unless stated.
- Reset mid-SHOW at scan=2 -> same cycle: digit_en=0, blank=1, scan=0, frame_done=0; after release with enable=1, mask=4'hF, the sequence restarts at digit 0.
- Full scan: mask=4'hF, enable rises -> repeating pattern:
  - per digit: 1 cycle blank, then 4 cycles digit_en = 0001, 0010, 0100, 1000 in turn, with scan = 0, 1, 2, 3 (20-cycle frame);
  - frame_done high on the blank cycle of digit 0 at every frame after the first, spaced 20 cycles.
- Skipping: mask=4'b1010 -> scan alternates 1, 3, 1, 3; digit_en=0010 then 1000; frame_done every 10 cycles, on entry to digit 1.
- Single digit and BLANK_CYCLES=0: mask=4'b0100 -> scan=2 constant, digit_en=0100 continuously, blank=0; frame_done pulses every 4 cycles.
- Enable drop mid-SHOW, then restart: enable=0 at cycle 2 of the digit-1 slot -> next cycle IDLE, digit_en=0. On re-enable the scan restarts at the lowest set bit after BLANK_CYCLES+1 cycles.
- Mask edits: mask cleared to 0 during the digit-3 slot -> slot completes, then IDLE, blank=1. Bit 1 cleared while digit 1 is showing -> digit 1 finishes, next selection skips it.
